mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
Memory-access stage controller between the execute stage and the write-back register.
- Accepts one instruction at a time from execute via a valid/ready handshake.
- Performs any load or store over a simple request/response data bus.
- Aligns and extends load data, then emits a one-cycle write enable (we_o) with the write-back fields for the downstream write-back register.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- XLEN, 32, datapath and bus width. Fixed at 32; lane logic assumes 4 byte lanes.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-low reset.
- valid_i  in  1  execute presents an instruction.
- ready_o  out  1  block can accept (high only in IDLE).
- mem_ren_i  in  1  instruction is a load.
- mem_wen_i  in  1  instruction is a store. Never high together with mem_ren_i.
- mem_op_i  in  3  funct3: LB/LH/LW/LBU/LHU or SB/SH/SW.
- alu_result_i  in  XLEN  ALU result; the effective address for memory ops.
- store_data_i  in  XLEN  rs2 value.
- wena_i  in  1  register write enable.
- wsel_i  in  1  write-back source select (ALU or memory).
- waddr_i  in  REG_ADDR_W  destination register.
- req_valid_o  out  1  bus request valid.
- req_ready_i  in  1  bus accepts request.
- req_addr_o  out  XLEN  word-aligned address {addr[31:2],2'b00}.
- req_wen_o  out  1  request is a write.
- req_wdata_o  out  XLEN  lane-shifted store data.
- req_wmask_o  out  4  byte strobes.
- rsp_valid_i  in  1  bus response (read data or write ack).
- rsp_rdata_i  in  XLEN  read data.
- we_o  out  1  one-cycle pulse: write-back fields valid.
- wena_o  out  1  registered write enable. Forced 0 on error.
- wsel_o  out  1  registered select.
- waddr_o  out  REG_ADDR_W  registered destination.
- alu_result_o  out  XLEN  registered ALU result.
- mem_result_o  out  XLEN  extended load data; 0 for non-loads.
- err_o  out  1  misaligned-access flag. Valid with we_o.

Behaviour:
- Reset is synchronous: when reset==0 at a clock edge, go to IDLE and clear every output register to 0. This includes req_valid_o, we_o, err_o and all data fields.
- Reset applies in any state, including mid-REQ or mid-WAIT. A response arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - ready_o=1.
  - On valid_i&ready_o, capture all inputs.
  - Next state is DONE if neither mem_ren_i nor mem_wen_i, or if the access is misaligned. Otherwise next state is REQ.
- REQ:
  - req_valid_o=1; address, wen, wdata and wmask are held stable until req_ready_i.
  - On req_ready_i go to WAIT.
  - rsp_valid_i is ignored in REQ; the bus guarantees the response is at least 1 cycle after acceptance.
- WAIT:
  - On rsp_valid_i, register the extended load data (reads) or just complete (write ack), then go to DONE.
- DONE:
  - we_o=1 for exactly one cycle; all *_o fields are stable.
  - Unconditionally return to IDLE. Downstream always accepts.
- Latency (valid_i accepted in cycle 0):
  - Non-memory op: we_o in cycle 1.
  - Memory op with req_ready_i and rsp_valid_i at their earliest: we_o in cycle 3.
  - Each bus stall adds one cycle per stall cycle.
- Misalignment: with off=addr[1:0], LH/LHU/SH with off odd, or LW/SW with off!=0, are misaligned.
  - No bus request is issued.
  - DONE with err_o=1, wena_o=0, mem_result_o=0.
- Load extraction:
  - LB/LBU: byte rdata[8*off+:8], sign- or zero-extended.
  - LH/LHU: half rdata[8*off+:16], sign- or zero-extended.
  - LW: full word.
- Store lanes:
  - SB: wmask=4'b0001<<off, wdata=data[7:0] replicated x4.
  - SH: wmask=4'b0011<<off, wdata=data[15:0] replicated x2.
  - SW: wmask=4'b1111.
  - For loads, wmask=0 and req_wen_o=0.
- Undefined mem_op_i encoding on a memory op: treated as misaligned (err_o=1).
- Registered outputs hold their last value between we_o pulses.

Decomposition:
- Shared defines.v holds:
  - funct3 encodings: MEM_LB..MEM_SW.
  - SEL_ALU_DATA / SEL_MEM_DATA.
  - FSM state encodings.
  - RESET_ENABLE (0).
- One combinational sub-module, mem_lsu_align, contains:
  - misalignment detect;
  - store lane shift and mask generation;
  - load byte/half extract and extension.
- The FSM and registers stay in mem_lsu.

Test Plan:
- ALU op (wena=1, waddr=5, alu=0x1234, no mem) -> we_o in cycle 1, wena_o=1, waddr_o=5, alu_result_o=0x1234, no req_valid_o.
- LB addr 0x1003, rdata 0x80AABBCC, zero-wait bus -> req_addr_o=0x1000, we_o in cycle 3, mem_result_o=0xFFFFFF80. Same access with LBU -> 0x00000080.
- SH addr 0x2002, data 0xDEADBEEF -> req_wmask_o=4'b1100, req_wdata_o=0xBEEFBEEF, req_wen_o=1, we_o after the ack.
- LW addr 0x3001 -> no req_valid_o, we_o in cycle 1 with err_o=1, wena_o=0.
- req_ready_i low 3 cycles, then rsp after 2 cycles -> req fields stable throughout, ready_o=0, we_o at cycle 8.
- Reset asserted in WAIT, then rsp_valid_i arrives -> IDLE, all outputs 0, no we_o pulse.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared encodings for the memory-access stage.
package mem_lsu_pkg;
  localparam logic [2:0] MEM_LB  = 3'b000;
  localparam logic [2:0] MEM_LH  = 3'b001;
  localparam logic [2:0] MEM_LW  = 3'b010;
  localparam logic [2:0] MEM_LBU = 3'b100;
  localparam logic [2:0] MEM_LHU = 3'b101;
  localparam logic [2:0] MEM_SB  = 3'b000;
  localparam logic [2:0] MEM_SH  = 3'b001;
  localparam logic [2:0] MEM_SW  = 3'b010;
  localparam logic SEL_ALU_DATA = 1'b0;
  localparam logic SEL_MEM_DATA = 1'b1;
  localparam logic RESET_ENABLE = 1'b0;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
endpackage

// File: rtl/mem_lsu_align.sv
// mem_lsu_align: misalignment detect, store lane steering and load extraction.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic        load,
  input  logic        store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic        err,
  output logic [31:0] wdata,
  output logic [3:0]  wmask,
  output logic [31:0] load_data
);
  logic        bad;
  logic [31:0] shifted;
  always_comb begin
    bad = 1'b1;
    case (op)
      MEM_LB:           bad = 1'b0;
      MEM_LH:           bad = off[0];
      MEM_LW:           bad = |off;
      MEM_LBU, MEM_LHU: bad = store | (op[0] & off[0]);
      default:          bad = 1'b1;
    endcase
    err = (load | store) & bad;
    shifted = rdata >> {off, 3'b000};
    wmask = !store ? 4'b0000 : op[1:0] == 2'b00 ? 4'b0001 << off : op[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
    wdata = op[1:0] == 2'b00 ? {4{store_data[7:0]}} : op[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
    load_data = op[1:0] == 2'b00 ? {{24{~op[2] & shifted[7]}}, shifted[7:0]}
              : op[1:0] == 2'b01 ? {{16{~op[2] & shifted[15]}}, shifted[15:0]} : rdata;
  end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: memory-access stage FSM between execute and the write-back register.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int XLEN       = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  mem_ren_i,
  input  logic                  mem_wen_i,
  input  logic [2:0]            mem_op_i,
  input  logic [XLEN-1:0]       alu_result_i,
  input  logic [XLEN-1:0]       store_data_i,
  input  logic                  wena_i,
  input  logic                  wsel_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [XLEN-1:0]       req_addr_o,
  output logic                  req_wen_o,
  output logic [XLEN-1:0]       req_wdata_o,
  output logic [3:0]            req_wmask_o,
  input  logic                  rsp_valid_i,
  input  logic [XLEN-1:0]       rsp_rdata_i,
  output logic                  we_o,
  output logic                  wena_o,
  output logic                  wsel_o,
  output logic [REG_ADDR_W-1:0] waddr_o,
  output logic [XLEN-1:0]       alu_result_o,
  output logic [XLEN-1:0]       mem_result_o,
  output logic                  err_o
);
  state_t                state, next;
  logic [2:0]            op_q;
  logic [XLEN-1:0]       addr_q, sdata_q, wdata, load_data;
  logic                  load_q, store_q, wena_q, wsel_q, err;
  logic [REG_ADDR_W-1:0] waddr_q;
  logic [3:0]            wmask;
  logic                  idle, req, direct, mem_done;
  assign idle = state == IDLE;
  assign req = state == REQ;
  assign direct = idle && next == DONE;
  assign mem_done = state == WAIT && rsp_valid_i;
  // In IDLE the aligner judges the incoming op; afterwards it works on the captured one.
  mem_lsu_align u_align (
    .op         (idle ? mem_op_i : op_q),
    .off        (idle ? alu_result_i[1:0] : addr_q[1:0]),
    .load       (idle ? mem_ren_i : load_q),
    .store      (idle ? mem_wen_i : store_q),
    .store_data (idle ? store_data_i : sdata_q),
    .rdata      (rsp_rdata_i),
    .err        (err),
    .wdata      (wdata),
    .wmask      (wmask),
    .load_data  (load_data)
  );
  always_ff @(posedge clock)
    state <= reset == RESET_ENABLE ? IDLE : next;
  always_comb
    next = state == IDLE ? (valid_i ? ((mem_ren_i | mem_wen_i) && !err ? REQ : DONE) : IDLE)
         : state == REQ  ? (req_ready_i ? WAIT : REQ)
         : state == WAIT ? (rsp_valid_i ? DONE : WAIT) : IDLE;
  always_comb begin
    ready_o = idle;
    req_valid_o = req;
    we_o = state == DONE;
    req_addr_o = req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    req_wen_o = req & store_q;
    req_wdata_o = req & store_q ? wdata : '0;
    req_wmask_o = req ? wmask : 4'b0000;
  end
  always_ff @(posedge clock)
    if (reset == RESET_ENABLE) begin
      {op_q, addr_q, sdata_q, load_q, store_q, wena_q, wsel_q, waddr_q} <= '0;
      {wena_o, wsel_o, waddr_o, alu_result_o, mem_result_o, err_o} <= '0;
    end else begin
      if (idle && valid_i) begin
        op_q <= mem_op_i;
        addr_q <= alu_result_i;
        sdata_q <= store_data_i;
        load_q <= mem_ren_i;
        store_q <= mem_wen_i;
        wena_q <= wena_i;
        wsel_q <= wsel_i;
        waddr_q <= waddr_i;
      end
      if (direct) begin
        wena_o <= wena_i & ~err;
        wsel_o <= wsel_i;
        waddr_o <= waddr_i;
        alu_result_o <= alu_result_i;
        mem_result_o <= '0;
        err_o <= err;
      end else if (mem_done) begin
        wena_o <= wena_q;
        wsel_o <= wsel_q;
        waddr_o <= waddr_q;
        alu_result_o <= addr_q;
        mem_result_o <= load_q ? load_data : '0;
        err_o <= 1'b0;
      end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed scenario bench for mem_lsu with hand-computed expectations.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i, ready_o, mem_ren_i, mem_wen_i;
  logic [2:0]  mem_op_i;
  logic [31:0] alu_result_i, store_data_i;
  logic        wena_i, wsel_i;
  logic [4:0]  waddr_i;
  logic        req_valid_o, req_ready_i, req_wen_o;
  logic [31:0] req_addr_o, req_wdata_o;
  logic [3:0]  req_wmask_o;
  logic        rsp_valid_i;
  logic [31:0] rsp_rdata_i;
  logic        we_o, wena_o, wsel_o, err_o;
  logic [4:0]  waddr_o;
  logic [31:0] alu_result_o, mem_result_o;
  int          passed = 0, total = 0;

  mem_lsu dut (
    .clock(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .mem_ren_i(mem_ren_i), .mem_wen_i(mem_wen_i), .mem_op_i(mem_op_i),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .wena_i(wena_i), .wsel_i(wsel_i), .waddr_i(waddr_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
    .req_wen_o(req_wen_o), .req_wdata_o(req_wdata_o), .req_wmask_o(req_wmask_o),
    .rsp_valid_i(rsp_valid_i), .rsp_rdata_i(rsp_rdata_i),
    .we_o(we_o), .wena_o(wena_o), .wsel_o(wsel_o), .waddr_o(waddr_o),
    .alu_result_o(alu_result_o), .mem_result_o(mem_result_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ren, input logic wen, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic wena, input logic [4:0] waddr);
    valid_i = 1'b1;
    mem_ren_i = ren;
    mem_wen_i = wen;
    mem_op_i = op;
    alu_result_i = addr;
    store_data_i = data;
    wena_i = wena;
    wsel_i = ren;
    waddr_i = waddr;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick();
    tick();
    total++; if (ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", ready_o); else passed++;
    total++; if ({we_o, req_valid_o, err_o, wena_o} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {we_o, req_valid_o, err_o, wena_o}); else passed++;
    total++; if ({alu_result_o, mem_result_o} !== 64'h0) $display("FAIL reset_data got %h want 0", {alu_result_o, mem_result_o}); else passed++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_alu;
    issue(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 1'b1, 5'd5);
    total++; if (ready_o !== 1'b1) $display("FAIL alu_ready got %b want 1", ready_o); else passed++;
    tick();
    valid_i = 1'b0;
    total++; if (we_o !== 1'b1) $display("FAIL alu_we_c1 got %b want 1", we_o); else passed++;
    total++; if ({wena_o, waddr_o} !== {1'b1, 5'd5}) $display("FAIL alu_wb got %b/%0d want 1/5", wena_o, waddr_o); else passed++;
    total++; if (alu_result_o !== 32'h1234) $display("FAIL alu_result got %h want 00001234", alu_result_o); else passed++;
    total++; if ({req_valid_o, err_o} !== 2'b00) $display("FAIL alu_noreq got %b want 00", {req_valid_o, err_o}); else passed++;
    tick();
    total++; if ({we_o, ready_o} !== 2'b01) $display("FAIL alu_pulse_end got %b want 01", {we_o, ready_o}); else passed++;
    total++; if (alu_result_o !== 32'h1234) $display("FAIL alu_hold got %h want 00001234", alu_result_o); else passed++;
  endtask

  task automatic test_load;
    logic [2:0]  ops[2] = '{3'b000, 3'b100};
    logic [31:0] exp[2] = '{32'hFFFFFF80, 32'h00000080};
    for (int i = 0; i < 2; i++) begin
      req_ready_i = 1'b1;
      issue(1'b1, 1'b0, ops[i], 32'h1003, 32'h0, 1'b1, 5'd7);
      tick();
      valid_i = 1'b0;
      total++; if ({req_valid_o, req_wen_o, req_wmask_o} !== 6'b100000) $display("FAIL ld%0d_req got %b want 100000", i, {req_valid_o, req_wen_o, req_wmask_o}); else passed++;
      total++; if (req_addr_o !== 32'h1000) $display("FAIL ld%0d_addr got %h want 00001000", i, req_addr_o); else passed++;
      tick();
      rsp_valid_i = 1'b1;
      rsp_rdata_i = 32'h80AABBCC;
      total++; if ({we_o, req_valid_o} !== 2'b00) $display("FAIL ld%0d_wait got %b want 00", i, {we_o, req_valid_o}); else passed++;
      tick();
      rsp_valid_i = 1'b0;
      total++; if (we_o !== 1'b1) $display("FAIL ld%0d_we_c3 got %b want 1", i, we_o); else passed++;
      total++; if (mem_result_o !== exp[i]) $display("FAIL ld%0d_data got %h want %h", i, mem_result_o, exp[i]); else passed++;
      total++; if ({wena_o, wsel_o, waddr_o, err_o} !== {1'b1, 1'b1, 5'd7, 1'b0}) $display("FAIL ld%0d_wb got %b want 1100111 0", i, {wena_o, wsel_o, waddr_o, err_o}); else passed++;
      tick();
    end
  endtask

  task automatic test_store;
    logic [2:0]  ops[2] = '{3'b001, 3'b000};
    logic [31:0] addr[2] = '{32'h2002, 32'h5001};
    logic [31:0] data[2] = '{32'hDEADBEEF, 32'h000000A5};
    logic [31:0] wd[2] = '{32'hBEEFBEEF, 32'hA5A5A5A5};
    logic [3:0]  wm[2] = '{4'b1100, 4'b0010};
    for (int i = 0; i < 2; i++) begin
      req_ready_i = 1'b1;
      issue(1'b0, 1'b1, ops[i], addr[i], data[i], 1'b0, 5'd0);
      tick();
      valid_i = 1'b0;
      total++; if ({req_valid_o, req_wen_o, req_wmask_o} !== {2'b11, wm[i]}) $display("FAIL st%0d_req got %b want %b", i, {req_valid_o, req_wen_o, req_wmask_o}, {2'b11, wm[i]}); else passed++;
      total++; if (req_wdata_o !== wd[i]) $display("FAIL st%0d_wdata got %h want %h", i, req_wdata_o, wd[i]); else passed++;
      total++; if (req_addr_o !== {addr[i][31:2], 2'b00}) $display("FAIL st%0d_addr got %h want %h", i, req_addr_o, {addr[i][31:2], 2'b00}); else passed++;
      tick();
      rsp_valid_i = 1'b1;
      tick();
      rsp_valid_i = 1'b0;
      total++; if ({we_o, err_o, wena_o} !== 3'b100) $display("FAIL st%0d_done got %b want 100", i, {we_o, err_o, wena_o}); else passed++;
      total++; if (mem_result_o !== 32'h0) $display("FAIL st%0d_memres got %h want 0", i, mem_result_o); else passed++;
      tick();
    end
  endtask

  task automatic test_misaligned;
    logic [2:0]  ops[2] = '{3'b010, 3'b011};
    logic [31:0] addr[2] = '{32'h3001, 32'h3000};
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, 1'b0, ops[i], addr[i], 32'h0, 1'b1, 5'd9);
      tick();
      valid_i = 1'b0;
      total++; if ({we_o, err_o, wena_o, req_valid_o} !== 4'b1100) $display("FAIL mis%0d_flags got %b want 1100", i, {we_o, err_o, wena_o, req_valid_o}); else passed++;
      total++; if ({mem_result_o, alu_result_o} !== {32'h0, addr[i]}) $display("FAIL mis%0d_data got %h want %h", i, {mem_result_o, alu_result_o}, {32'h0, addr[i]}); else passed++;
      tick();
    end
  endtask

  task automatic test_stall;
    issue(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 1'b1, 5'd3);
    req_ready_i = 1'b0;
    tick();
    valid_i = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      req_ready_i = c == 4;
      rsp_valid_i = c == 7;
      rsp_rdata_i = c == 7 ? 32'h12345678 : 32'hFFFFFFFF;
      total++; if (we_o !== 1'b0 || ready_o !== 1'b0) $display("FAIL stall_c%0d_busy got we=%b rdy=%b want 0/0", c, we_o, ready_o); else passed++;
      if (c <= 4) begin
        total++; if ({req_valid_o, req_addr_o, req_wmask_o} !== {1'b1, 32'h4000, 4'b0000}) $display("FAIL stall_c%0d_req got %b/%h want 1/00004000", c, req_valid_o, req_addr_o); else passed++;
      end
      tick();
    end
    rsp_valid_i = 1'b0;
    req_ready_i = 1'b1;
    total++; if (we_o !== 1'b1) $display("FAIL stall_we_c8 got %b want 1", we_o); else passed++;
    total++; if (mem_result_o !== 32'h12345678) $display("FAIL stall_data got %h want 12345678", mem_result_o); else passed++;
    tick();
  endtask

  task automatic test_reset_mid;
    issue(1'b1, 1'b0, 3'b010, 32'h6000, 32'h0, 1'b1, 5'd4);
    req_ready_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    rsp_valid_i = 1'b1;
    rsp_rdata_i = 32'hCAFEF00D;
    total++; if ({ready_o, we_o, req_valid_o} !== 3'b100) $display("FAIL rst_mid_state got %b want 100", {ready_o, we_o, req_valid_o}); else passed++;
    total++; if ({alu_result_o, waddr_o, wena_o} !== '0) $display("FAIL rst_mid_clear got %h/%0d/%b want 0", alu_result_o, waddr_o, wena_o); else passed++;
    tick();
    rsp_valid_i = 1'b0;
    total++; if ({we_o, mem_result_o} !== 33'h0) $display("FAIL rst_mid_ignore got %b/%h want 0/0", we_o, mem_result_o); else passed++;
    tick();
    total++; if ({we_o, ready_o} !== 2'b01) $display("FAIL rst_mid_idle got %b want 01", {we_o, ready_o}); else passed++;
  endtask

  initial begin
    valid_i = 1'b0;
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
    valid_i = 1'b0;
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_rdata_i = 32'h0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misaligned();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
